// File: rtl/mmu_readout.sv
// mmu_readout: fetches captured 32-bit sample words from the MMU one at a time
// and serialises their enabled byte groups, LSB group first, onto a byte-wide
// valid/ready stream toward the UART transmitter.
// Optional feature macro: LOGIP_READOUT_ABORT_EN adds abort_i, which returns a
// running transfer to IDLE and drops any byte not yet accepted.
module mmu_readout #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             start_i,
    input  logic [CNT_W-1:0] read_cnt_i,
    input  logic [3:0]       grp_en_i,
`ifdef LOGIP_READOUT_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             mem_read_o,
    input  logic [31:0]      mem_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_stb_o,
    input  logic             tx_rdy_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;
    logic [3:0]       grp_en_reg, grp_en_next;
    logic [2:0]       lat_cnt_reg, lat_cnt_next;
    logic [31:0]      word_reg, word_next;
    logic [1:0]       idx_reg, idx_next;

    logic             abort;
    logic [3:0]       pending;
    logic [3:0]       above;
    logic [7:0]       word_bytes [4];
    logic [1:0]       cur_idx;
    logic             cur_valid;
    logic             more_after;
    logic             word_end;

`ifdef LOGIP_READOUT_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Per-group views: enabled groups at or beyond the byte index, groups
    // above the current one, and the byte lanes of the captured word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign pending[gi]    = grp_en_reg[gi] && (idx_reg <= 2'(gi));
            assign above[gi]      = (2'(gi) > cur_idx);
            assign word_bytes[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    // Lowest pending enabled group is the byte currently offered; disabled
    // groups are skipped without spending a cycle.
    always_comb begin
        cur_idx   = 2'd0;
        cur_valid = |pending;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) cur_idx = 2'(i);
        end
        more_after = |(grp_en_reg & above);
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_reg    <= S_IDLE;
            word_cnt_reg <= '0;
            grp_en_reg   <= '0;
            lat_cnt_reg  <= '0;
            word_reg     <= '0;
            idx_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            grp_en_reg   <= grp_en_next;
            lat_cnt_reg  <= lat_cnt_next;
            word_reg     <= word_next;
            idx_reg      <= idx_next;
        end
    end

    // Next-state and output decode; outputs depend only on state and
    // registered data so a pending byte stays stable while stalled.
    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        grp_en_next   = grp_en_reg;
        lat_cnt_next  = lat_cnt_reg;
        word_next     = word_reg;
        idx_next      = idx_reg;
        word_end      = 1'b0;
        mem_read_o    = 1'b0;
        tx_data_o     = 8'h00;
        tx_stb_o      = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_i && !abort) begin
                    word_cnt_next = read_cnt_i;
                    grp_en_next   = grp_en_i;
                    state_next    = S_REQ;
                end
            end
            S_REQ: begin
                busy_o       = 1'b1;
                mem_read_o   = 1'b1;
                lat_cnt_next = LAT_INIT;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                busy_o       = 1'b1;
                lat_cnt_next = lat_cnt_reg - 3'd1;
                if (lat_cnt_reg == 3'd1) begin
                    word_next  = mem_i;
                    idx_next   = 2'd0;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                busy_o = 1'b1;
                if (cur_valid) begin
                    tx_stb_o  = 1'b1;
                    tx_data_o = word_bytes[cur_idx];
                    if (tx_rdy_i) begin
                        if (more_after) idx_next = cur_idx + 2'd1;
                        else            word_end = 1'b1;
                    end
                end else begin
                    word_end = 1'b1;
                end
                if (word_end) begin
                    if (word_cnt_reg == '0) begin
                        state_next = S_DONE;
                    end else begin
                        word_cnt_next = word_cnt_reg - CNT_W'(1);
                        state_next    = S_REQ;
                    end
                end
            end
            S_DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            mem_read_o = 1'b0;
            tx_stb_o   = 1'b0;
            tx_data_o  = 8'h00;
            done_o     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mmu_readout.sv
// Testbench for mmu_readout: an MMU model with garbage outside the valid
// latency slot, a ready pattern generator, a byte scoreboard and directed
// transfers. Covers LOGIP_READOUT_ABORT_EN when that macro is defined.
module tb_mmu_readout;

    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 4;

    logic             clk_i = 1'b0;
    logic             rst_in = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] read_cnt_i = '0;
    logic [3:0]       grp_en_i = '0;
`ifdef LOGIP_READOUT_ABORT_EN
    logic             abort_i = 1'b0;
`endif
    logic             mem_read_o;
    logic [31:0]      mem_i = '0;
    logic [7:0]       tx_data_o;
    logic             tx_stb_o;
    logic             tx_rdy_i = 1'b0;
    logic             busy_o;
    logic             done_o;

    mmu_readout #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .start_i    (start_i),
        .read_cnt_i (read_cnt_i),
        .grp_en_i   (grp_en_i),
`ifdef LOGIP_READOUT_ABORT_EN
        .abort_i    (abort_i),
`endif
        .mem_read_o (mem_read_o),
        .mem_i      (mem_i),
        .tx_data_o  (tx_data_o),
        .tx_stb_o   (tx_stb_o),
        .tx_rdy_i   (tx_rdy_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] mem_q[$];
    logic [7:0]  exp_q[$];
    int          strobes = 0;
    int          bytes_seen = 0;
    int          done_seen = 0;
    int          stb_cycles = 0;
    int          rdy_mode = 0;
    int          lat_left = 0;
    int          cyc = 0;
    logic        hold_pending = 1'b0;
    logic [7:0]  held_data = '0;
    int          s0, b0, d0, c0, n_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // MMU model and ready generator, updated just after each rising edge.
    // mem_i carries the word only in the cycle MEM_LAT after the strobe.
    initial forever begin
        @(posedge clk_i);
        #1;
        cyc++;
        case (rdy_mode)
            0:       tx_rdy_i = 1'b1;
            1:       tx_rdy_i = ((cyc % 3) == 2);
            default: tx_rdy_i = 1'b0;
        endcase
        if (!rst_in) begin
            lat_left = 0;
            mem_i    = $urandom;
        end else begin
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0 && mem_q.size() > 0) mem_i = mem_q.pop_front();
                else                                   mem_i = $urandom;
            end else begin
                mem_i = $urandom;
            end
            if (mem_read_o) begin
                strobes++;
                lat_left = MEM_LAT;
            end
        end
    end

    // Output monitor: scoreboard pops on each accepted byte; a stalled byte
    // must stay stable until it is taken.
    initial forever begin
        @(negedge clk_i);
        if (!rst_in) begin
            hold_pending = 1'b0;
        end else begin
            if (done_o) done_seen++;
            if (tx_stb_o) begin
                stb_cycles++;
                if (hold_pending) check("hold_data", 32'(tx_data_o), 32'(held_data));
                if (tx_rdy_i) begin
                    bytes_seen++;
                    hold_pending = 1'b0;
                    if (exp_q.size() > 0) check("byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
                    else                  check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    hold_pending = 1'b1;
                    held_data    = tx_data_o;
                end
            end else if (hold_pending) begin
                check("stb_dropped", 32'(tx_stb_o), 32'd1);
                hold_pending = 1'b0;
            end
        end
    end

    task automatic begin_xfer(input logic [CNT_W-1:0] cnt, input logic [3:0] grp);
        for (int w = 0; w <= int'(cnt); w++) begin
            for (int k = 0; k < 4; k++) begin
                if (grp[k]) exp_q.push_back(mem_q[w][8*k +: 8]);
            end
        end
        n_exp = exp_q.size();
        s0 = strobes;
        b0 = bytes_seen;
        d0 = done_seen;
        c0 = stb_cycles;
        @(negedge clk_i);
        read_cnt_i = cnt;
        grp_en_i   = grp;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int n_words, input bit strict_timing);
        int t = 0;
        while (done_seen == d0 && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        check({tag, "_timeout"}, 32'(t < 3000), 32'd1);
        @(negedge clk_i);
        check({tag, "_done"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_strobes"}, 32'(strobes - s0), 32'(n_words));
        check({tag, "_bytes"}, 32'(bytes_seen - b0), 32'(n_exp));
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        if (strict_timing) check({tag, "_stbcyc"}, 32'(stb_cycles - c0), 32'(n_exp));
        $display("xfer %s: words=%0d bytes=%0d strobes=%0d", tag, n_words, bytes_seen - b0, strobes - s0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", 32'({mem_read_o, tx_stb_o, busy_o, done_o, tx_data_o}), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_i);
        check("idle_busy", 32'(busy_o), 32'd0);

        rdy_mode = 0;
        mem_q.push_back(32'hA1B2C3D4);
        begin_xfer(4'd0, 4'b1111);
        finish_xfer("single", 1, 1'b1);

        mem_q.push_back(32'h11223344);
        mem_q.push_back(32'h55667788);
        begin_xfer(4'd1, 4'b0101);
        finish_xfer("partial", 2, 1'b1);

        rdy_mode = 1;
        mem_q.push_back(32'hCAFEF00D);
        begin_xfer(4'd0, 4'b1111);
        finish_xfer("backpressure", 1, 1'b0);
        rdy_mode = 0;

        mem_q.push_back(32'h0BADBEEF);
        begin_xfer(4'd0, 4'b1111);
        @(negedge clk_i);
        @(negedge clk_i);
        read_cnt_i = 4'd5;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
        finish_xfer("restart_ignored", 1, 1'b1);

        for (int i = 0; i < 4; i++) mem_q.push_back($urandom);
        begin_xfer(4'd3, 4'b0000);
        finish_xfer("no_groups", 4, 1'b1);

        for (int i = 0; i < 16; i++) mem_q.push_back(32'h5A000000 + 32'(i * 17));
        begin_xfer(4'd15, 4'b0001);
        finish_xfer("max_count", 16, 1'b1);

        rdy_mode = 2;
        mem_q.push_back(32'h12345678);
        begin_xfer(4'd0, 4'b1111);
        t = 0;
        while (!tx_stb_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("rst_reach_send", 32'(tx_stb_o), 32'd1);
        d0 = done_seen;
        @(negedge clk_i);
        #2;
        rst_in = 1'b0;
        #1;
        check("rst_async_outputs", 32'({mem_read_o, tx_stb_o, busy_o, done_o, tx_data_o}), 32'd0);
        repeat (3) @(negedge clk_i);
        check("rst_no_done", 32'(done_seen - d0), 32'd0);
        exp_q.delete();
        mem_q.delete();
        rst_in   = 1'b1;
        rdy_mode = 0;
        $display("xfer reset_mid_send: dropped in-flight byte");

        mem_q.push_back(32'h9ABCDEF0);
        mem_q.push_back(32'h13579BDF);
        begin_xfer(4'd1, 4'b1010);
        finish_xfer("after_reset", 2, 1'b1);

`ifdef LOGIP_READOUT_ABORT_EN
        for (int i = 0; i < 4; i++) mem_q.push_back(32'hC0DE0000 + 32'(i));
        begin_xfer(4'd3, 4'b1111);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("abort_strobes", 32'(strobes - s0), 32'd1);
        check("abort_bytes", 32'(bytes_seen - b0), 32'd0);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        mem_q.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_beats_start", 32'(busy_o), 32'd0);
        $display("xfer abort_in_wait: strobes=%0d bytes=%0d", strobes - s0, bytes_seen - b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_readout.md
Name: mmu_readout

Overview:
- Read-side counterpart of the sample MMU.
- After a capture, drives the MMU read strobe to fetch stored 32-bit sample words one at a time.
- Serialises the enabled byte groups of each word, LSB group first, onto a byte-wide valid/ready stream feeding the UART transmitter.
- Sits between the MMU and the TX path; started by the command decoder.

Parameters:
- MEM_LAT, 1, cycles from a mem_read_o pulse until mem_i holds valid data (range 1..4).
- CNT_W, 16, width of the word-count input.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_in  in  1  asynchronous reset, active low.
- start_i  in  1  one-cycle start request from the command decoder.
- read_cnt_i  in  CNT_W  number of words to read minus one.
- grp_en_i  in  4  byte-group enables; bit k enables byte k (bits 8k+7:8k).
- mem_read_o  out  1  one-cycle read strobe to the MMU.
- mem_i  in  32  read data from the MMU (MMU mem_o).
- tx_data_o  out  8  byte to the transmitter.
- tx_stb_o  out  1  tx_data_o valid.
- tx_rdy_i  in  1  transmitter accepts the byte this cycle.
- busy_o  out  1  readout in progress.
- done_o  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, rst_in=0):
  - All outputs 0; FSM to IDLE; counters and latches cleared.
  - Takes effect immediately, including mid-transfer.
  - Any byte in flight is dropped; no done_o.
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE:
  - busy_o=0.
  - On start_i=1: latch read_cnt_i into word counter, latch grp_en_i, go to REQ.
  - start_i is ignored in every other state.
- REQ:
  - mem_read_o=1 for exactly this cycle.
  - Load latency counter with MEM_LAT; go to WAIT.
- WAIT:
  - Decrement latency counter.
  - At 0, capture mem_i into a 32-bit word register; byte index=0; go to SEND.
- SEND, per byte index k=0..3:
  - If latched grp_en[k]=0, skip k in the same cycle (no strobe, no stall cycle for disabled groups).
  - Otherwise drive tx_data_o=word[8k+7:8k] with tx_stb_o=1.
  - Hold tx_data_o and tx_stb_o stable until a cycle with tx_rdy_i=1; the transfer completes on that edge.
  - tx_stb_o never drops before acceptance.
  - After byte 3 (or after the last enabled group):
    - word counter=0 -> DONE;
    - else decrement the counter -> REQ.
- grp_en=0000:
  - Words are still read (read_cnt+1 strobes), no bytes are emitted.
  - Each word passes through SEND in one cycle.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in REQ, WAIT, SEND, DONE.
- Back-to-back bytes: with tx_rdy_i held 1, one enabled byte per cycle.
- Word count:
  - read_cnt_i=0 means one word.
  - The maximum value means 2^CNT_W words.
  - The counter does not wrap.
- Total mem_read_o pulses = read_cnt+1.
- Total bytes = (read_cnt+1) * popcount(grp_en).
- mem_i is sampled only at the end of WAIT; other values are ignored.

Optional Feature:
- Macro: LOGIP_READOUT_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in any non-IDLE state goes to IDLE on the next edge with mem_read_o=0, tx_stb_o=0, done_o=0.
  - Any byte not yet accepted is dropped.
  - abort_i in IDLE is ignored; abort wins over a simultaneous start_i.
- Undefined:
  - Port absent; a transfer always runs to completion or reset.

Test Plan:
- Single word: read_cnt=0, grp_en=1111, mem_i=0xA1B2C3D4, tx_rdy_i=1 -> one mem_read_o pulse; bytes D4, C3, B2, A1 on consecutive cycles; done_o pulse; busy_o low after.
- Partial groups: read_cnt=1, grp_en=0101, words 0x11223344 then 0x55667788 -> bytes 44, 22, 88, 66; exactly 2 read strobes.
- Backpressure: tx_rdy_i toggles 0,0,1 repeatedly, 1 word, grp_en=1111 -> each byte is held stable across stalled cycles and sent exactly once, in order.
- Latency: MEM_LAT=3, mem_i valid only on cycle 3 after the strobe (garbage before) -> correct word captured.
- Restart and edge cases:
  - start_i pulsed while busy is ignored; byte count is unchanged.
  - grp_en=0000 with read_cnt=3 -> 4 strobes, 0 bytes, done_o.
- Reset mid-op (plus abort when LOGIP_READOUT_ABORT_EN is defined):
  - rst_in low during SEND -> outputs 0 immediately, no done_o.
  - A new start after release works normally.
  - With the macro: abort_i during WAIT -> IDLE, no further strobes.
